// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock FIFO with a show-ahead (first-word-fall-through)
// read port and registered full/empty flags.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        synchronous reset, active-high; wins over push/pop
//   push       enqueue write_data this edge (accepted if not full, or if full
//              and pop is also requested)
//   pop        drop the head entry this edge (accepted if not empty)
//   write_data word to enqueue
//   read_data  head entry, combinational from storage; valid while empty=0
//   empty      FIFO holds 0 entries
//   full       FIFO holds DEPTH entries
//
// DEPTH need not be a power of two: pointers wrap explicitly at DEPTH-1.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] read_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]               count, count_nxt;
  logic                        do_push, do_pop;

  // A pop always frees the head slot, so a push at full is legal when paired
  // with a pop; the popped word is read before the slot is overwritten.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop);

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers, count and flags. Flags come from count_nxt so they are correct
  // right after the edge with no extra cycle of latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CNT_FULL);
    end
  end

  // Storage is not reset; contents are only observable once written.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= write_data;
  end

  assign read_data = mem[rd_ptr];

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] write_data = '0;
  logic [WIDTH-1:0] read_data;
  logic             empty, full;

  int n_tests = 0;
  int n_fail  = 0;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .write_data (write_data),
    .read_data  (read_data),
    .empty      (empty),
    .full       (full)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs, take the edge, sample 1 unit later.
  task automatic step(input logic r, input logic ps, input logic pp, input logic [WIDTH-1:0] d);
    rst = r; push = ps; pop = pp; write_data = d;
    @(posedge clk);
    #1;
    rst = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] w;
  logic             rp, rq;

  initial begin
    // Reset state
    step(1'b1, 1'b0, 1'b0, '0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);

    // Fill and drain: 0x00,0x11,...,0xFF
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'(i * 8'h11));
      chk("fill_full",  32'(full),  (i == DEPTH - 1) ? 32'd1 : 32'd0);
      chk("fill_empty", 32'(empty), 32'd0);
      chk("fill_head",  32'(read_data), 32'h00);
    end
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_data", 32'(read_data), 32'(i * 8'h11));
      step(1'b0, 1'b0, 1'b1, '0);
      chk("drain_full", 32'(full), 32'd0);
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Half-fill streaming: word j of the input stream is (j%16)*0x11
    for (int j = 0; j < 8; j++) step(1'b0, 1'b1, 1'b0, 8'((j % 16) * 8'h11));
    for (int k = 0; k < 80; k++) begin
      chk("strm_data", 32'(read_data), 32'((k % 16) * 8'h11));
      step(1'b0, 1'b1, 1'b1, 8'(((k + 8) % 16) * 8'h11));
      chk("strm_empty", 32'(empty), 32'd0);
      chk("strm_full",  32'(full),  32'd0);
    end
    for (int k = 80; k < 88; k++) begin
      chk("strm_tail", 32'(read_data), 32'((k % 16) * 8'h11));
      step(1'b0, 1'b0, 1'b1, '0);
    end
    chk("strm_done_empty", 32'(empty), 32'd1);

    // Full boundary: fill with 0xA0..0xAF
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'(8'hA0 + i));
    chk("fb_full", 32'(full), 32'd1);
    chk("fb_head_before", 32'(read_data), 32'hA0);
    step(1'b0, 1'b1, 1'b1, 8'hAB);
    chk("fb_pp_full", 32'(full), 32'd1);
    chk("fb_pp_head", 32'(read_data), 32'hA1);
    step(1'b0, 1'b1, 1'b0, 8'hCD);
    chk("fb_ovf_full", 32'(full), 32'd1);
    chk("fb_ovf_head", 32'(read_data), 32'hA1);
    for (int i = 1; i < DEPTH; i++) begin
      chk("fb_drain", 32'(read_data), 32'(8'hA0 + i));
      step(1'b0, 1'b0, 1'b1, '0);
    end
    chk("fb_last_word", 32'(read_data), 32'hAB);
    chk("fb_last_nonempty", 32'(empty), 32'd0);
    step(1'b0, 1'b0, 1'b1, '0);
    chk("fb_empty", 32'(empty), 32'd1);

    // Empty boundary
    step(1'b0, 1'b0, 1'b1, '0);
    chk("eb_pop_empty", 32'(empty), 32'd1);
    chk("eb_pop_full",  32'(full),  32'd0);
    step(1'b0, 1'b1, 1'b1, 8'h5A);
    chk("eb_pp_empty", 32'(empty), 32'd0);
    chk("eb_pp_data",  32'(read_data), 32'h5A);
    step(1'b0, 1'b0, 1'b1, '0);
    chk("eb_pp_drained", 32'(empty), 32'd1);

    // Reset mid-operation with 5 entries; push during reset must be dropped
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
    chk("rm_pre_head", 32'(read_data), 32'h10);
    step(1'b1, 1'b1, 1'b0, 8'hEE);
    chk("rm_empty", 32'(empty), 32'd1);
    chk("rm_full",  32'(full),  32'd0);
    step(1'b0, 1'b1, 1'b0, 8'h3C);
    chk("rm_push_data",  32'(read_data), 32'h3C);
    chk("rm_push_empty", 32'(empty), 32'd0);
    step(1'b0, 1'b0, 1'b1, '0);
    chk("rm_drained", 32'(empty), 32'd1);

    // Randomized against a queue model
    q.delete();
    for (int c = 0; c < 200; c++) begin
      rp = ($urandom_range(99) < 60);
      rq = ($urandom_range(99) < 50);
      if (q.size() == DEPTH && $urandom_range(99) < 40) begin
        rp = 1'b1; rq = 1'b1;
      end
      w = 8'($urandom);
      begin
        bit acc_pop, acc_push;
        acc_pop  = rq && (q.size() > 0);
        acc_push = rp && ((q.size() < DEPTH) || rq);
        step(1'b0, rp, rq, w);
        if (acc_pop)  void'(q.pop_front());
        if (acc_push) q.push_back(w);
      end
      chk("rnd_empty", 32'(empty), (q.size() == 0) ? 32'd1 : 32'd0);
      chk("rnd_full",  32'(full),  (q.size() == DEPTH) ? 32'd1 : 32'd0);
      if (q.size() > 0) chk("rnd_data", 32'(read_data), 32'(q[0]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
